// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Purpose  : Instruction-fetch queue at the consumer end of the PC interface.
//            Each valid PC becomes a one-cycle-latency word read. The returned
//            instruction and its PC are stored in a small FIFO and handed to
//            decode over valid/ready. holdpc stalls the PC stage so the FIFO
//            never overflows. A flush discards queued and in-flight fetches.
// Options  : FETCH_BYPASS_EN - when defined, an empty queue forwards the
//            returning read data straight to decode (1-cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_valid,
  output logic            holdpc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            flush,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_valid,
  input  logic            id_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = AW + 2;
  localparam logic [TW-1:0] c_DEPTH_TOKENS = TW'(DEPTH);

  // Reject depths the pointer arithmetic cannot wrap correctly.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("if_fetch_queue: DEPTH must be a power of two and at least 2");
  end

  logic [XLEN-1:0] r_mem_instr [DEPTH];
  logic [XLEN-1:0] r_mem_pc    [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            r_pending_valid;
  logic [XLEN-1:0] r_pending_pc;

  logic            w_req;
  logic            w_fifo_nonempty;
  logic            w_bypass;
  logic            w_bypass_take;
  logic            w_push;
  logic            w_pop;
  logic [TW-1:0]   w_tokens;

  // A fetch is issued for every valid PC unless a redirect is killing it.
  assign w_req     = pc_valid & ~flush & ~rst;
  assign imem_req  = w_req;
  assign imem_addr = w_req ? pc_in : '0;

`ifdef FETCH_BYPASS_EN
  // Returning data may skip the FIFO only when nothing older is queued.
  assign w_bypass = (r_count == '0) & r_pending_valid & ~flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_bypass_take   = w_bypass & id_ready;
  assign w_fifo_nonempty = (r_count != '0);
  // A flush cycle still shows the head entry but never consumes it.
  assign w_pop           = w_fifo_nonempty & id_ready & ~flush;
  assign w_push          = r_pending_valid & ~flush & ~w_bypass_take;

  // Credits: queued entries, the read in flight and the PC offered now. Pops
  // are not credited, so a push can never land in a full FIFO.
  assign w_tokens = TW'(r_count) + TW'(r_pending_valid) + TW'(pc_valid);
  assign holdpc   = rst | (w_tokens >= c_DEPTH_TOKENS);

  // Decode-side view: FIFO head first, then the bypass path, else zeros.
  always_comb begin
    id_valid = 1'b0;
    id_instr = '0;
    id_pc    = '0;
    if (w_fifo_nonempty) begin
      id_valid = 1'b1;
      id_instr = r_mem_instr[r_rd_ptr];
      id_pc    = r_mem_pc[r_rd_ptr];
    end else if (w_bypass) begin
      id_valid = 1'b1;
      id_instr = imem_rdata;
      id_pc    = r_pending_pc;
    end
  end

  // Track the single outstanding read so its data can be paired with its PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending_valid <= 1'b0;
      r_pending_pc    <= '0;
    end else begin
      r_pending_valid <= w_req;
      r_pending_pc    <= pc_in;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are only observable through a valid entry.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= imem_rdata;
      r_mem_pc[r_wr_ptr]    <= r_pending_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_queue
// Purpose  : Directed, table-driven bench for if_fetch_queue with a one-cycle
//            instruction memory model and hand-written reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] pc_in;
  logic            pc_valid;
  logic            holdpc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            flush;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic            id_valid;
  logic            id_ready;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        fl;
    logic        rdy;
    logic        e_req;
    logic        e_hold;
    logic        e_val;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  if_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .holdpc     (holdpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .flush      (flush),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_valid   (id_valid),
    .id_ready   (id_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory word at a given address: easy to recognise in a trace.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Instruction memory: data appears the cycle after the request.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? word_at(imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // The queue must never be asked to accept data while full.
  always @(negedge clk) begin
    if (!rst && dut.r_count == 3'(DEPTH) && dut.r_pending_valid && !flush) begin
      n_err++;
      $display("FAIL overflow: push into full FIFO, count %0d", dut.r_count);
    end
  end

  function automatic vec_t mk(input logic pv, input logic [31:0] pc, input logic fl,
                              input logic rdy, input logic e_req, input logic e_hold,
                              input logic e_val, input logic [31:0] e_pc,
                              input logic [2:0] e_cnt);
    vec_t v;
    v.pv = pv; v.pc = pc; v.fl = fl; v.rdy = rdy;
    v.e_req = e_req; v.e_hold = e_hold; v.e_val = e_val; v.e_pc = e_pc; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Drive one cycle's inputs (at edge+1), compare mid-cycle, then clock.
  task automatic apply(input vec_t v, input int idx);
    pc_valid = v.pv;
    pc_in    = v.pc;
    flush    = v.fl;
    id_ready = v.rdy;
    #3;
    chk($sformatf("v%0d imem_req", idx), 32'(imem_req), 32'(v.e_req));
    chk($sformatf("v%0d imem_addr", idx), imem_addr, v.e_req ? v.pc : 32'h0);
    chk($sformatf("v%0d holdpc", idx), 32'(holdpc), 32'(v.e_hold));
    chk($sformatf("v%0d id_valid", idx), 32'(id_valid), 32'(v.e_val));
    chk($sformatf("v%0d id_pc", idx), id_pc, v.e_val ? v.e_pc : 32'h0);
    chk($sformatf("v%0d id_instr", idx), id_instr, v.e_val ? word_at(v.e_pc) : 32'h0);
    chk($sformatf("v%0d count", idx), 32'(dut.r_count), 32'(v.e_cnt));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    pc_valid = 1'b1;
    pc_in    = 32'h5;
    flush    = 1'b0;
    id_ready = 1'b0;
    #2;
    chk("reset imem_req", 32'(imem_req), 32'h0);
    chk("reset imem_addr", imem_addr, 32'h0);
    chk("reset holdpc", 32'(holdpc), 32'h1);
    chk("reset id_valid", 32'(id_valid), 32'h0);
    chk("reset id_pc", id_pc, 32'h0);
    chk("reset id_instr", id_instr, 32'h0);
    pc_valid = 1'b0;
    pc_in    = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef FETCH_BYPASS_EN
    // Bypass: consumed directly when ready, otherwise written to the FIFO.
    tbl.push_back(mk(1, 32'h20, 0, 1, 1, 0, 0, 32'h0,  0));
    tbl.push_back(mk(0, 32'h0,  0, 1, 0, 0, 1, 32'h20, 0));
    tbl.push_back(mk(1, 32'h21, 0, 0, 1, 0, 0, 32'h0,  0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0, 1, 32'h21, 0));
    tbl.push_back(mk(0, 32'h0,  0, 1, 0, 0, 1, 32'h21, 1));
    tbl.push_back(mk(0, 32'h0,  0, 1, 0, 0, 0, 32'h0,  0));
`else
    // Stream 1,2,3 with decode ready: first id_valid two cycles after pc_valid.
    tbl.push_back(mk(1, 32'h1,  0, 1, 1, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 32'h2,  0, 1, 1, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 32'h3,  0, 1, 1, 0, 1, 32'h1,  1));
    tbl.push_back(mk(0, 32'h0,  0, 1, 0, 0, 1, 32'h2,  1));
    tbl.push_back(mk(0, 32'h0,  0, 1, 0, 0, 1, 32'h3,  1));
    tbl.push_back(mk(0, 32'h0,  0, 1, 0, 0, 0, 32'h0,  0));
    // Backpressure: holdpc once tokens reach DEPTH, count saturates at 4.
    tbl.push_back(mk(1, 32'h4,  0, 0, 1, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 32'h5,  0, 0, 1, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 32'h6,  0, 0, 1, 0, 1, 32'h4,  1));
    tbl.push_back(mk(1, 32'h7,  0, 0, 1, 1, 1, 32'h4,  2));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1, 1, 32'h4,  3));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1, 1, 32'h4,  4));
    // Drain in order, then streaming resumes.
    tbl.push_back(mk(0, 32'h0,  0, 1, 0, 1, 1, 32'h4,  4));
    tbl.push_back(mk(0, 32'h0,  0, 1, 0, 0, 1, 32'h5,  3));
    tbl.push_back(mk(1, 32'h8,  0, 1, 1, 0, 1, 32'h6,  2));
    tbl.push_back(mk(1, 32'h9,  0, 1, 1, 0, 1, 32'h7,  1));
    tbl.push_back(mk(0, 32'h0,  0, 1, 0, 0, 1, 32'h8,  1));
    // Ready toggling; push and pop together at count 2 (pointers wrap).
    tbl.push_back(mk(1, 32'hA,  0, 0, 1, 0, 1, 32'h9,  1));
    tbl.push_back(mk(1, 32'hB,  0, 0, 1, 0, 1, 32'h9,  1));
    tbl.push_back(mk(0, 32'h0,  0, 1, 0, 0, 1, 32'h9,  2));
    tbl.push_back(mk(0, 32'h0,  0, 1, 0, 0, 1, 32'hA,  2));
    tbl.push_back(mk(0, 32'h0,  0, 1, 0, 0, 1, 32'hB,  1));
    // Flush with three queued, one pending and a new PC offered.
    tbl.push_back(mk(1, 32'h20, 0, 0, 1, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 32'h21, 0, 0, 1, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 32'h22, 0, 0, 1, 0, 1, 32'h20, 1));
    tbl.push_back(mk(1, 32'h23, 0, 0, 1, 1, 1, 32'h20, 2));
    tbl.push_back(mk(1, 32'h24, 1, 1, 0, 1, 1, 32'h20, 3));
    tbl.push_back(mk(0, 32'h0,  0, 1, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 32'h30, 0, 1, 1, 0, 0, 32'h0,  0));
    tbl.push_back(mk(0, 32'h0,  0, 1, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(0, 32'h0,  0, 1, 0, 0, 1, 32'h30, 1));
    tbl.push_back(mk(0, 32'h0,  0, 1, 0, 0, 0, 32'h0,  0));
`endif

    foreach (tbl[i]) apply(tbl[i], i);

    // Asynchronous reset in mid-cycle with entries queued and a read in flight.
    pc_valid = 1'b1; pc_in = 32'h40; id_ready = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    pc_in = 32'h41;
    @(posedge clk); #1;
    pc_in = 32'h42;
    #2;
    chk("pre-reset imem_req", 32'(imem_req), 32'h1);
    rst = 1'b1;
    #1;
    chk("midreset id_valid", 32'(id_valid), 32'h0);
    chk("midreset imem_req", 32'(imem_req), 32'h0);
    chk("midreset holdpc", 32'(holdpc), 32'h1);
    chk("midreset id_pc", id_pc, 32'h0);
    chk("midreset count", 32'(dut.r_count), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; pc_valid = 1'b0; pc_in = 32'h0; id_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #3;
      chk($sformatf("postreset%0d id_valid", k), 32'(id_valid), 32'h0);
      chk($sformatf("postreset%0d holdpc", k), 32'(holdpc), 32'h0);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Consumer end of the program-counter interface in the pipelined core.
- Takes each valid PC from the PC stage and issues a word read to instruction memory with one-cycle latency.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Drives holdpc back to the PC stage so the queue never overflows; a flush from EX discards all buffered and in-flight fetches.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- XLEN, 32, instruction and PC width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_in  in  XLEN  word-addressed PC from the PC stage (pc_reg_out).
- pc_valid  in  1  PC-stage valid (if_id_ins_valid).
- holdpc  out  1  stall request to the PC stage.
- imem_req  out  1  instruction memory read strobe.
- imem_addr  out  XLEN  instruction memory word address.
- imem_rdata  in  XLEN  read data, valid the cycle after imem_req.
- flush  in  1  branch/jump redirect; kill all queued and in-flight work.
- id_instr  out  XLEN  instruction to decode.
- id_pc  out  XLEN  PC of id_instr.
- id_valid  out  1  id_instr/id_pc valid.
- id_ready  in  1  decode accepts this cycle.

Behaviour:
- Reset (async, rst=1): count=0, rd_ptr=wr_ptr=0, pending_valid=0, pending_pc=0.
  - Outputs during reset: id_valid=0, id_instr=0, id_pc=0, imem_req=0, imem_addr=0, holdpc=1.
  - holdpc is forced to 1 combinationally while rst is high.
- Issue (combinational):
  - imem_req = pc_valid & ~flush; imem_addr = pc_in when imem_req=1, else 0.
  - At the edge: pending_valid <= imem_req; pending_pc <= pc_in.
- Capture: in the cycle where pending_valid=1 and flush=0, imem_rdata and pending_pc are written to FIFO[wr_ptr] at the edge; wr_ptr increments mod DEPTH.
- Output: id_valid = (count != 0); id_instr/id_pc = FIFO[rd_ptr], forced to 0 when empty.
- Pop: on id_valid & id_ready, rd_ptr increments mod DEPTH.
- Count: push and pop in the same cycle leave count unchanged; pointers wrap independently.
- Latency: pc_valid in cycle N -> imem_req in N -> write at end of N+1 -> id_valid in N+2.
- Credit rule:
  - tokens = count + pending_valid + pc_valid; holdpc = rst | (tokens >= DEPTH).
  - Pops are not credited (conservative), so occupancy never exceeds DEPTH.
  - A push into a full FIFO is impossible by construction; the bench asserts this.
- Flush (highest priority):
  - At the edge: count=0, rd_ptr=wr_ptr, pending_valid=0.
  - Same cycle: imem_req=0, and the pc_valid/pending data present that cycle is discarded.
  - Also in the flush cycle: id_valid is still driven from state, but a pop is ignored.
- holdpc falls the cycle after a flush as tokens drop.
- Reset mid-operation clears all state immediately; any in-flight imem_rdata is ignored.
- Counter widths: count is clog2(DEPTH)+1 bits; pointers are clog2(DEPTH) bits.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- When defined, and count==0, pending_valid=1 and flush=0:
  - id_valid=1, id_instr=imem_rdata, id_pc=pending_pc combinationally.
  - If id_ready=1 the entry is consumed without writing the FIFO; otherwise it is written as normal.
  - Minimum latency becomes 1 cycle (id_valid in N+1).
- When undefined, outputs come only from FIFO registers; latency is 2.

Test Plan:
- Reset: rst=1 asynchronously mid-cycle -> id_valid=0, imem_req=0, holdpc=1 immediately. After release with id_ready=1 and pc_valid stream 1,2,3 -> id_pc=1,2,3 with id_instr equal to memory words, first id_valid 2 cycles after pc_valid (1 with FETCH_BYPASS_EN).
- Backpressure: id_ready=0, DEPTH=4, continuous pc_valid -> holdpc=1 once tokens reach 4, count saturates at 4, no push while full. Raising id_ready drains pc 1..4 in order, then streaming resumes.
- Wrap: 10 PCs through with id_ready toggling 1,0,1,0 -> all 10 delivered in order, none duplicated, pointers wrap twice.
- Flush: queue holding pc 5,6,7, pending 8, pc_valid with pc 9, flush=1 for one cycle -> imem_req=0 that cycle, next cycle id_valid=0, count=0; pc 8 and 9 never appear at decode.
- Simultaneous: count=2, push and pop in the same cycle -> count stays 2, id_pc advances by one.
- Bypass (FETCH_BYPASS_EN defined): empty queue, id_ready=1, pc_valid pc=0x20 -> id_valid in the next cycle with id_pc=0x20, FIFO count remains 0.
